// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter sharing one 8-bit 16:1 mux among 16 requesters.
// Drives registered, glitch-free mux selects s3..s0 for the whole grant.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   req_i      request vector, bit i requests mux input i
//   release_i  one-cycle pulse from the holder ending its grant
//   s0_o..s3_o mux select bits (s0 = LSB), index of the granted requester
//   grant_o    registered one-hot grant
//   busy_o     high while a grant is held
//   timeout_o  one-cycle pulse when a grant is ended by the hold limit only
module mux16_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] req_i,
    input  logic        release_i,
    output logic        s0_o,
    output logic        s1_o,
    output logic        s2_o,
    output logic        s3_o,
    output logic [15:0] grant_o,
    output logic        busy_o,
    output logic        timeout_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    // With the timeout disabled the counter just parks at all-ones.
    localparam logic [CNT_W-1:0] CNT_SAT  =
        (MAX_HOLD == 0) ? {CNT_W{1'b1}} : HOLD_MAX;

    state_t           state_q, state_d;
    logic [3:0]       sel_q, sel_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [15:0]      grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic             pick_vld;
    logic [3:0]       pick_idx;
    logic [3:0]       scan_idx;
    logic             to_hit;
    logic             hold_end;

    // Search ptr, ptr+1, ... with 4-bit wrap. Scanning from the far end
    // down lets the lowest offset from ptr win the last assignment.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 4'd0;
        scan_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            scan_idx = ptr_q + 4'(i);
            if (req_i[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    assign to_hit   = (MAX_HOLD != 0) && (cnt_q == HOLD_MAX);
    assign hold_end = release_i || !req_i[sel_q] || to_hit;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    grant_d = 16'd1 << pick_idx;
                    cnt_d   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (hold_end) begin
                    state_d   = IDLE;
                    grant_d   = 16'd0;
                    // Holder drops to lowest priority for the next pick.
                    ptr_d     = sel_q + 4'd1;
                    cnt_d     = '0;
                    // A coincident release or req drop counts as normal.
                    timeout_d = to_hit && !release_i && req_i[sel_q];
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sel_q     <= 4'd0;
            ptr_q     <= 4'd0;
            grant_q   <= 16'd0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign s0_o      = sel_q[0];
    assign s1_o      = sel_q[1];
    assign s2_o      = sel_q[2];
    assign s3_o      = sel_q[3];
    assign grant_o   = grant_q;
    assign busy_o    = (state_q == GRANT);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed testbench for mux16_rr_arbiter.
// Uses MAX_HOLD=4 so the hold-limit path is reachable quickly.
module tb_mux16_rr_arbiter;

    logic        clk;
    logic        reset_n;
    logic [15:0] req_i;
    logic        release_i;
    logic        s0_o, s1_o, s2_o, s3_o;
    logic [15:0] grant_o;
    logic        busy_o;
    logic        timeout_o;
    logic [3:0]  sel;

    int checks = 0;
    int errors = 0;

    assign sel = {s3_o, s2_o, s1_o, s0_o};

    mux16_rr_arbiter #(
        .MAX_HOLD(4),
        .CNT_W   (5)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_i    (req_i),
        .release_i(release_i),
        .s0_o     (s0_o),
        .s1_o     (s1_o),
        .s2_o     (s2_o),
        .s3_o     (s3_o),
        .grant_o  (grant_o),
        .busy_o   (busy_o),
        .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_i     = 16'h0000;
        release_i = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_i     = 16'h0000;
        release_i = 1'b0;
        step();
        step();
        checks++;
        if (grant_o !== 16'h0 || busy_o !== 1'b0 ||
            sel !== 4'd0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got g=%h b=%b s=%0d t=%b exp 0 0 0 0",
                     grant_o, busy_o, sel, timeout_o);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (grant_o !== 16'h0) begin
            errors++;
            $display("FAIL idle_noreq got %h exp 0000", grant_o);
        end
        req_i = 16'h0001;
        step();
        checks++;
        if (grant_o !== 16'h0001 || sel !== 4'd0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL t1_grant got g=%h s=%0d b=%b exp 0001 0 1",
                     grant_o, sel, busy_o);
        end
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        checks++;
        if (grant_o !== 16'h0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL t1_release got g=%h b=%b exp 0000 0",
                     grant_o, busy_o);
        end
        // ptr should now be 1: with req 0 and 1 both set, 1 wins.
        req_i = 16'h0003;
        step();
        checks++;
        if (grant_o !== 16'h0002 || sel !== 4'd1) begin
            errors++;
            $display("FAIL t1_ptr1 got g=%h s=%0d exp 0002 1", grant_o, sel);
        end
        req_i = 16'h0000;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        req_i = 16'h8001;
        step();
        checks++;
        if (grant_o !== 16'h0001 || sel !== 4'd0) begin
            errors++;
            $display("FAIL t2_first got g=%h s=%0d exp 0001 0", grant_o, sel);
        end
        step();
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        checks++;
        if (grant_o !== 16'h0) begin
            errors++;
            $display("FAIL t2_idle1 got %h exp 0000", grant_o);
        end
        step();
        checks++;
        if (grant_o !== 16'h8000 || sel !== 4'd15) begin
            errors++;
            $display("FAIL t2_second got g=%h s=%0d exp 8000 15", grant_o, sel);
        end
        step();
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        checks++;
        if (grant_o !== 16'h0 || sel !== 4'd15) begin
            errors++;
            $display("FAIL t2_idle2 got g=%h s=%0d exp 0000 15", grant_o, sel);
        end
        step();
        checks++;
        if (grant_o !== 16'h0001 || sel !== 4'd0) begin
            errors++;
            $display("FAIL t2_wrap got g=%h s=%0d exp 0001 0", grant_o, sel);
        end
        req_i = 16'h0000;
        step();
        step();
    endtask

    task automatic test_rotate();
        logic [15:0] exp_g;
        logic [3:0]  exp_s;
        do_reset();
        req_i = 16'hFFFF;
        step();
        for (int k = 0; k < 17; k++) begin
            exp_s = 4'(k % 16);
            exp_g = 16'd1 << exp_s;
            checks++;
            if (grant_o !== exp_g || sel !== exp_s) begin
                errors++;
                $display("FAIL t3_rr%0d got g=%h s=%0d exp %h %0d",
                         k, grant_o, sel, exp_g, exp_s);
            end
            step();
            release_i = 1'b1;
            step();
            release_i = 1'b0;
            checks++;
            if (grant_o !== 16'h0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL t3_gap%0d got g=%h b=%b exp 0000 0",
                         k, grant_o, busy_o);
            end
            step();
        end
        req_i = 16'h0000;
        step();
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        req_i = 16'h0010;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (grant_o !== 16'h0010 || timeout_o !== 1'b0) begin
                errors++;
                $display("FAIL t4_hold%0d got g=%h t=%b exp 0010 0",
                         k, grant_o, timeout_o);
            end
        end
        step();
        checks++;
        if (grant_o !== 16'h0 || timeout_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL t4_expire got g=%h t=%b b=%b exp 0000 1 0",
                     grant_o, timeout_o, busy_o);
        end
        step();
        checks++;
        if (grant_o !== 16'h0010 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL t4_regrant got g=%h t=%b exp 0010 0",
                     grant_o, timeout_o);
        end
        // Release lands on the same edge as the hold limit.
        step();
        step();
        step();
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        checks++;
        if (grant_o !== 16'h0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL t4_coincide got g=%h t=%b exp 0000 0",
                     grant_o, timeout_o);
        end
        req_i = 16'h0000;
        step();
        step();
    endtask

    task automatic test_req_drop();
        do_reset();
        req_i = 16'h0008;
        step();
        checks++;
        if (grant_o !== 16'h0008 || sel !== 4'd3) begin
            errors++;
            $display("FAIL t5_grant got g=%h s=%0d exp 0008 3", grant_o, sel);
        end
        req_i = 16'h0030;
        step();
        checks++;
        if (grant_o !== 16'h0 || timeout_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL t5_drop got g=%h t=%b b=%b exp 0000 0 0",
                     grant_o, timeout_o, busy_o);
        end
        step();
        checks++;
        if (grant_o !== 16'h0010 || sel !== 4'd4) begin
            errors++;
            $display("FAIL t5_next got g=%h s=%0d exp 0010 4", grant_o, sel);
        end
        req_i = 16'h0000;
        step();
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        req_i = 16'h1000;
        step();
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        req_i = 16'h0200;
        step();
        checks++;
        if (grant_o !== 16'h0200 || sel !== 4'd9) begin
            errors++;
            $display("FAIL t6_pre got g=%h s=%0d exp 0200 9", grant_o, sel);
        end
        step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (grant_o !== 16'h0 || busy_o !== 1'b0 || sel !== 4'd0) begin
            errors++;
            $display("FAIL t6_async got g=%h b=%b s=%0d exp 0000 0 0",
                     grant_o, busy_o, sel);
        end
        #1;
        reset_n = 1'b1;
        // ptr back to 0 means 9 beats 13.
        req_i = 16'h2200;
        step();
        checks++;
        if (grant_o !== 16'h0200 || sel !== 4'd9) begin
            errors++;
            $display("FAIL t6_ptr0 got g=%h s=%0d exp 0200 9", grant_o, sel);
        end
        req_i = 16'h0000;
        step();
        // release while idle must not disturb anything.
        release_i = 1'b1;
        req_i = 16'h0004;
        step();
        release_i = 1'b0;
        checks++;
        if (grant_o !== 16'h0004 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL t6_idlerel got g=%h b=%b exp 0004 1",
                     grant_o, busy_o);
        end
        req_i = 16'h0000;
        step();
    endtask

    initial begin
        reset_n   = 1'b0;
        req_i     = 16'h0000;
        release_i = 1'b0;
        test_reset();
        test_wrap();
        test_rotate();
        test_timeout();
        test_req_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
